// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared field positions and control-bundle layout for the decode stage
package pipe_pkg;

  localparam int CTL_W   = 11;
  localparam int EXCTL_W = 9;

  // cu_ctl = {m2reg, wmem, shift, aluimm, wreg, sext, sst, aluc[3:0]}
  localparam int M2REG    = 10;
  localparam int WMEM     = 9;
  localparam int SHIFT    = 8;
  localparam int ALUIMM   = 7;
  localparam int WREG     = 6;
  localparam int SEXT     = 5;
  localparam int SST      = 4;
  localparam int ALUC_MSB = 3;
  localparam int ALUC_LSB = 0;

  // ex_ctl = {m2reg, wmem, shift, aluimm, wreg, aluc[3:0]}
  localparam int EX_M2REG = 8;
  localparam int EX_WREG  = 4;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 20;
  localparam int IMM_HI = 25;
  localparam int IMM_LO = 10;
  localparam int RDA_LO = 10;
  localparam int RS_LO  = 5;
  localparam int RT_LO  = 0;

  function automatic logic [EXCTL_W-1:0] ex_ctl_of(input logic [CTL_W-1:0] c);
    return {c[M2REG], c[WMEM], c[SHIFT], c[ALUIMM], c[WREG], c[ALUC_MSB:ALUC_LSB]};
  endfunction

endpackage

// File: rtl/regfile_p.sv
// rtl/regfile_p.sv - register file with r0 tied to zero and write-through read bypass
module regfile_p #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wn,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra_a,
  input  logic [AW-1:0]   ra_b,
  output logic [XLEN-1:0] qa,
  output logic [XLEN-1:0] qb
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && wn != '0) regs_d[wn] = wd;
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // A write landing this cycle is visible to the reader immediately.
  assign qa = (ra_a == '0) ? '0 : (we && wn == ra_a) ? wd : regs_q[ra_a];
  assign qb = (ra_b == '0) ? '0 : (we && wn == ra_b) ? wd : regs_q[ra_b];

endmodule

// File: rtl/pipe_id.sv
// rtl/pipe_id.sv - decode stage: operand fetch, immediate, load-use interlock, ID/EX register
module pipe_id import pipe_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int STALL_W = 16,
  localparam int AW     = $clog2(NREG)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst,
  output logic [11:0]        cu_op,
  input  logic [CTL_W-1:0]   cu_ctl,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_wn,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [EXCTL_W-1:0] ex_ctl,
  output logic [XLEN-1:0]    ex_qa,
  output logic [XLEN-1:0]    ex_qb,
  output logic [XLEN-1:0]    ex_imm,
  output logic [AW-1:0]      ex_drd,
  output logic [AW-1:0]      ex_rs,
  output logic [AW-1:0]      ex_rt,
  output logic [STALL_W-1:0] stall_cnt
);

  logic [AW-1:0]      rs_idx, rt_idx, rda_idx, drd;
  logic [15:0]        imm16;
  logic [XLEN-1:0]    qa, qb, imm_ext;
  logic               hazard, adv;

  logic               ex_valid_q, ex_valid_d;
  logic [EXCTL_W-1:0] ex_ctl_q, ex_ctl_d;
  logic [XLEN-1:0]    ex_qa_q, ex_qa_d, ex_qb_q, ex_qb_d, ex_imm_q, ex_imm_d;
  logic [AW-1:0]      ex_drd_q, ex_drd_d, ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  assign cu_op   = inst[OP_HI:OP_LO];
  assign rs_idx  = inst[RS_LO +: AW];
  assign rt_idx  = inst[RT_LO +: AW];
  assign rda_idx = inst[RDA_LO +: AW];
  assign imm16   = inst[IMM_HI:IMM_LO];
  assign imm_ext = cu_ctl[SEXT] ? XLEN'($signed(imm16)) : XLEN'(imm16);
  assign drd     = cu_ctl[SST] ? rda_idx : rt_idx;

  regfile_p #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clock (clock),
    .reset (reset),
    .we    (wb_we),
    .wn    (wb_wn),
    .wd    (wb_data),
    .ra_a  (rs_idx),
    .ra_b  (rt_idx),
    .qa    (qa),
    .qb    (qb)
  );

  // A load sitting in ID/EX cannot forward its data in time for a dependent decode.
  assign hazard   = ex_valid_q && ex_ctl_q[EX_M2REG] && ex_ctl_q[EX_WREG] && ex_drd_q != '0
                    && (ex_drd_q == rs_idx || ex_drd_q == rt_idx);
  assign adv      = !ex_valid_q || ex_ready;
  assign in_ready = adv && !hazard && !flush;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_ctl_d   = ex_ctl_q;
    ex_qa_d    = ex_qa_q;
    ex_qb_d    = ex_qb_q;
    ex_imm_d   = ex_imm_q;
    ex_drd_d   = ex_drd_q;
    ex_rs_d    = ex_rs_q;
    ex_rt_d    = ex_rt_q;
    stall_d    = stall_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (adv && in_valid && !hazard) begin
      ex_valid_d = 1'b1;
      ex_ctl_d   = ex_ctl_of(cu_ctl);
      ex_qa_d    = qa;
      ex_qb_d    = qb;
      ex_imm_d   = imm_ext;
      ex_drd_d   = drd;
      ex_rs_d    = rs_idx;
      ex_rt_d    = rt_idx;
    end else if (adv) begin
      ex_valid_d = 1'b0;
    end
    if (adv && in_valid && hazard && !flush && stall_q != '1)
      stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_q <= 1'b0;
      ex_ctl_q   <= '0;
      ex_qa_q    <= '0;
      ex_qb_q    <= '0;
      ex_imm_q   <= '0;
      ex_drd_q   <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      stall_q    <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctl_q   <= ex_ctl_d;
      ex_qa_q    <= ex_qa_d;
      ex_qb_q    <= ex_qb_d;
      ex_imm_q   <= ex_imm_d;
      ex_drd_q   <= ex_drd_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      stall_q    <= stall_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_ctl    = ex_ctl_q;
  assign ex_qa     = ex_qa_q;
  assign ex_qb     = ex_qb_q;
  assign ex_imm    = ex_imm_q;
  assign ex_drd    = ex_drd_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign stall_cnt = stall_q;

endmodule

// File: doc/pipe_id.md
Name: pipe_id

Overview:
- Parametrised decode stage for the pipelined successor of the single-cycle core.
- Contains the register file with write-back bypass, operand/immediate generation and destination select.
- Adds load-use interlock and a valid/ready handshake on both sides, registered into an ID/EX pipeline register with flush.
- Sits between the IF stage (instruction side) and EX; the combinational control unit stays external and is driven from the cu_op port.

Parameters:
- XLEN, 32, datapath/register width; immediates are extended to XLEN.
- NREG, 32, number of architectural registers (power of two, ≤32). r0 is hardwired to zero.
- AW, $clog2(NREG), register index width. Derived; not overridden.
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset.
- in_valid  in  1  IF presents a valid instruction.
- in_ready  out  1  Decode accepts the instruction this cycle.
- inst  in  32  Instruction. Fields: op=[31:20], imm16=[25:10], rdA=[14:10], rs=[9:5], rt=[4:0].
- cu_op  out  12  inst[31:20], driven to the external control unit.
- cu_ctl  in  11  Control bundle {m2reg,wmem,shift,aluimm,wreg,sext,sst,aluc[3:0]}.
- wb_we, wb_wn[AW], wb_data[XLEN]  in  Write-back port.
- flush  in  1  Kill the instruction in decode and the ID/EX contents.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_ready  in  1  EX accepts ID/EX this cycle.
- ex_ctl  out  9  {m2reg,wmem,shift,aluimm,wreg,aluc[3:0]}.
- ex_qa, ex_qb, ex_imm  out  XLEN  Operands and extended immediate.
- ex_drd, ex_rs, ex_rt  out  AW  Destination and source indices; rs/rt are exported for downstream forwarding.
- stall_cnt  out  STALL_W  Saturating count of load-use bubbles.

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared, r0..r(NREG-1) included.
  - ex_valid=0; ex_ctl, ex_qa, ex_qb, ex_imm, ex_drd, ex_rs, ex_rt all 0; stall_cnt=0.
  - in_ready reflects the equations below (i.e. 1 after reset).
- Register file: synchronous write on the clock edge when wb_we && wb_wn!=0; writes to r0 are ignored. Reads are combinational.
- Write-through bypass: if wb_we && wb_wn==rs && rs!=0, the rs read returns wb_data in the same cycle. The rt read is handled the same way.
- Register index: register index = field[AW-1:0] (upper bits ignored when NREG<32).
- Immediate: imm16 extended to XLEN.
  - Sign-extended when cu_ctl.sext=1, zero-extended otherwise.
  - If XLEN<16, imm16 is truncated to its low XLEN bits.
- Destination: drd = sst ? rdA : rt.
- Hazard: hazard = ex_valid && ex_ctl.m2reg && ex_ctl.wreg && ex_drd!=0 && (ex_drd==rs || ex_drd==rt).
- Handshake:
  - adv = !ex_valid || ex_ready.
  - in_ready = adv && !hazard && !flush.
  - Instruction transfers when in_valid && in_ready.
- ID/EX update, in priority order:
  1. flush: ex_valid<=0; other fields don't-care/hold.
  2. adv && in_valid && !hazard: load the decoded bundle, ex_valid<=1.
  3. adv (bubble or no input): ex_valid<=0.
  4. Otherwise hold all fields. This is backpressure; outputs stay stable while ex_valid && !ex_ready.
- stall_cnt: increments by 1 on each cycle where adv && in_valid && hazard && !flush. Saturates at all-ones.
- Latency: 1 cycle from accept to ex_valid. Throughput is 1 instruction per cycle with no hazard; a load-use inserts exactly one bubble.
- Simultaneous write-back and decode of the same register: the bypass ensures the new value is captured.
- Flush during a hazard: the flush wins and the counter does not increment.
- Reset mid-transfer: the in-flight instruction is lost; IF re-fetches.

Decomposition:
- Shared package pipe_pkg holds:
  - CTL field index constants (M2REG … ALUC_LSB);
  - instruction field positions (OP_HI/LO, IMM_HI/LO, RDA/RS/RT);
  - CTL_W=11 and EXCTL_W=9.
- One sub-module: regfile_p (parameters XLEN, NREG; async active-low reset, r0 zero, write-through bypass).
- Hazard, handshake and ID/EX logic stay in pipe_id.

Test Plan:
- Reset then write: reset low for 2 cycles, then wb write r3=0x12345678. Decode rs=3, rt=0 → ex_qa=0x12345678, ex_qb=0, ex_valid=1 one cycle after accept.
- Bypass: wb_we=1, wb_wn=5, wb_data=0xA5A5A5A5 in the same cycle that an inst with rs=5 is accepted → ex_qa=0xA5A5A5A5. Writing r0=0xFFFFFFFF, then reading r0 → 0.
- Immediate: imm16=0x8001 with sext=1 → ex_imm=0xFFFF8001; with sext=0 → 0x00008001. sst=1, rdA=7, rt=2 → ex_drd=7.
- Load-use: load (m2reg=1, wreg=1, drd=4) followed by an inst with rt=4 → in_ready=0 for one cycle, one bubble (ex_valid=0), then the dependent inst is accepted. stall_cnt=1.
- Backpressure: ex_ready=0 for 3 cycles with ex_valid=1 → in_ready=0 and all ex_* outputs are stable. On ex_ready=1 the next inst loads.
- Flush: flush=1 while ex_valid=1 and in_valid=1 → next cycle ex_valid=0, the input is not accepted and stall_cnt is unchanged. STALL_W=2 with 5 hazards → stall_cnt saturates at 3.
